// File: rtl/decode_stage.sv
// RV32I decode stage: turns one instruction word into a registered control bundle.
// Latency 1 cycle from accept to out_valid; one bundle register, 1 instr/cycle sustained.
// Backpressure: in_ready = !out_valid | out_ready; a stalled bundle holds every output stable.
module decode_stage (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        flush_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src,
  output logic [31:0] imm,
  output logic [31:0] pc_out,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jalr,
  output logic [2:0]  funct3_out,
  output logic        illegal
);

  // ALU operation codes seen by the execute stage.
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_LUI   = 4'b1010;
  localparam logic [3:0] ALU_AUIPC = 4'b1011;

  // Major opcodes decoded by this stage; anything else is flagged illegal.
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Which immediate layout the current opcode uses.
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  // Everything the execute stage needs, captured together in one register.
  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic        illegal;
  } bundle_t;

  // Instruction fields.
  logic [6:0] f_opcode;
  logic [4:0] f_rd;
  logic [2:0] f_funct3;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;
  logic [6:0] f_funct7;

  assign f_opcode = in_instr[6:0];
  assign f_rd     = in_instr[11:7];
  assign f_funct3 = in_instr[14:12];
  assign f_rs1    = in_instr[19:15];
  assign f_rs2    = in_instr[24:20];
  assign f_funct7 = in_instr[31:25];

  // All immediate layouts, sign-extended from bit 31.
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // Shared funct3 -> ALU op mapping for the register and immediate ALU forms.
  function automatic logic [3:0] base_alu_op(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Raw per-opcode decode, before the illegal-encoding squash.
  logic [3:0] dec_alu;
  logic       dec_src;
  imm_fmt_t   dec_fmt;
  logic       dec_wr;
  logic       dec_load;
  logic       dec_store;
  logic       dec_branch;
  logic       dec_jal;
  logic       dec_jalr;
  logic       dec_bad;

  // Classify the opcode and pick ALU op, operand source and immediate layout.
  always_comb begin
    dec_alu    = ALU_ADD;
    dec_src    = 1'b0;
    dec_fmt    = IMM_NONE;
    dec_wr     = 1'b0;
    dec_load   = 1'b0;
    dec_store  = 1'b0;
    dec_branch = 1'b0;
    dec_jal    = 1'b0;
    dec_jalr   = 1'b0;
    dec_bad    = 1'b0;
    case (f_opcode)
      OPC_OP_IMM: begin
        dec_src = 1'b1;
        dec_fmt = IMM_I;
        dec_wr  = 1'b1;
        dec_alu = base_alu_op(f_funct3);
        if (f_funct3 == 3'b001) begin
          dec_bad = (f_funct7 != F7_BASE);
        end else if (f_funct3 == 3'b101) begin
          if (f_funct7 == F7_ALT) begin
            dec_alu = ALU_SRA;
          end else if (f_funct7 != F7_BASE) begin
            dec_bad = 1'b1;
          end
        end
      end
      OPC_OP: begin
        dec_wr = 1'b1;
        if (f_funct7 == F7_BASE) begin
          dec_alu = base_alu_op(f_funct3);
        end else if (f_funct7 == F7_ALT) begin
          case (f_funct3)
            3'b000:  dec_alu = ALU_SUB;
            3'b101:  dec_alu = ALU_SRA;
            default: dec_bad = 1'b1;
          endcase
        end else begin
          dec_bad = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_alu = ALU_LUI;
        dec_src = 1'b1;
        dec_fmt = IMM_U;
        dec_wr  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_alu = ALU_AUIPC;
        dec_src = 1'b1;
        dec_fmt = IMM_U;
        dec_wr  = 1'b1;
      end
      OPC_LOAD: begin
        dec_src  = 1'b1;
        dec_fmt  = IMM_I;
        dec_wr   = 1'b1;
        dec_load = 1'b1;
        // LB, LH, LW, LBU, LHU only.
        dec_bad  = (f_funct3 == 3'b011) || (f_funct3 == 3'b110) || (f_funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec_src   = 1'b1;
        dec_fmt   = IMM_S;
        dec_store = 1'b1;
        // SB, SH, SW only.
        dec_bad   = f_funct3[2] || (f_funct3 == 3'b011);
      end
      OPC_BRANCH: begin
        dec_alu    = ALU_SUB;
        dec_fmt    = IMM_B;
        dec_branch = 1'b1;
        // funct3 010 and 011 are unassigned branch conditions.
        dec_bad    = (f_funct3[2:1] == 2'b01);
      end
      OPC_JAL: begin
        dec_src = 1'b1;
        dec_fmt = IMM_J;
        dec_wr  = 1'b1;
        dec_jal = 1'b1;
      end
      OPC_JALR: begin
        dec_src  = 1'b1;
        dec_fmt  = IMM_I;
        dec_wr   = 1'b1;
        dec_jalr = 1'b1;
      end
      default: begin
        dec_bad = 1'b1;
      end
    endcase
  end

  // Immediate select driven by the layout chosen above.
  logic [31:0] imm_val;

  // Route the selected immediate layout; register-register ops carry zero.
  always_comb begin
    imm_val = 32'd0;
    case (dec_fmt)
      IMM_I:   imm_val = imm_i;
      IMM_S:   imm_val = imm_s;
      IMM_B:   imm_val = imm_b;
      IMM_U:   imm_val = imm_u;
      IMM_J:   imm_val = imm_j;
      default: imm_val = 32'd0;
    endcase
  end

  bundle_t nxt;

  // Assemble the bundle; an illegal encoding keeps only the raw fields and the flag,
  // so nothing downstream can write a register or touch memory on it.
  always_comb begin
    nxt         = '0;
    nxt.pc      = in_pc;
    nxt.rs1     = f_rs1;
    nxt.rs2     = f_rs2;
    nxt.rd      = f_rd;
    nxt.funct3  = f_funct3;
    nxt.illegal = dec_bad;
    if (!dec_bad) begin
      nxt.alu_ctrl  = dec_alu;
      nxt.alu_src   = dec_src;
      nxt.imm       = imm_val;
      nxt.is_load   = dec_load;
      nxt.is_store  = dec_store;
      nxt.is_branch = dec_branch;
      nxt.is_jal    = dec_jal;
      nxt.is_jalr   = dec_jalr;
      // x0 is hardwired, so a write to it is simply dropped.
      nxt.reg_write = dec_wr && (f_rd != 5'd0);
    end
  end

  // Handshake: the single register can take a new bundle whenever it is empty or draining.
  logic    valid_q;
  bundle_t bundle_q;
  logic    accept;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register; flush beats accept, and the bundle only loads on accept so a stall holds it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else if (flush_in) begin
      valid_q  <= 1'b0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      bundle_q <= nxt;
    end else if (out_ready) begin
      valid_q  <= 1'b0;
    end
  end

  assign out_valid  = valid_q;
  assign alu_ctrl   = bundle_q.alu_ctrl;
  assign alu_src    = bundle_q.alu_src;
  assign imm        = bundle_q.imm;
  assign pc_out     = bundle_q.pc;
  assign rs1        = bundle_q.rs1;
  assign rs2        = bundle_q.rs2;
  assign rd         = bundle_q.rd;
  assign reg_write  = bundle_q.reg_write;
  assign is_load    = bundle_q.is_load;
  assign is_store   = bundle_q.is_store;
  assign is_branch  = bundle_q.is_branch;
  assign is_jal     = bundle_q.is_jal;
  assign is_jalr    = bundle_q.is_jalr;
  assign funct3_out = bundle_q.funct3;
  assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus randomized traffic vs a reference model.
// Latency: model expects each accepted instruction on the outputs one cycle later.
// Backpressure: out_ready and flush_in randomized; stalled bundles must hold.
module tb_decode_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic        alu_src;
  logic [31:0] imm;
  logic [31:0] pc_out;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3_out;
  logic        illegal;

  decode_stage dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .flush_in   (flush_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_ctrl   (alu_ctrl),
    .alu_src    (alu_src),
    .imm        (imm),
    .pc_out     (pc_out),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .reg_write  (reg_write),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .funct3_out (funct3_out),
    .illegal    (illegal)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Class flag order: {load, store, branch, jal, jalr}.
  localparam logic [4:0] CL_LOAD   = 5'b10000;
  localparam logic [4:0] CL_STORE  = 5'b01000;
  localparam logic [4:0] CL_BRANCH = 5'b00100;
  localparam logic [4:0] CL_JAL    = 5'b00010;
  localparam logic [4:0] CL_JALR   = 5'b00001;

  typedef struct packed {
    logic [3:0]  alu;
    logic        src;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic [4:0]  cls;
    logic [2:0]  f3;
    logic        ill;
    logic        chk_alu;
    logic        chk_src;
    logic        chk_imm;
  } exp_t;

  // ALU code indexed by funct3 for the plain (funct7 = 0) ALU forms.
  logic [3:0] base_alu [8];

  // Reference decode straight from the ISA rules, immediates built arithmetically.
  function automatic exp_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
    exp_t       e;
    int         s;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         legal;
    bit         writes;
    int         imm_i, imm_s, imm_b, imm_j;
    e      = '0;
    s      = instr;
    opc    = instr[6:0];
    f3     = instr[14:12];
    f7     = instr[31:25];
    imm_i  = s >>> 20;
    imm_s  = ((s >>> 25) << 5) | int'(instr[11:7]);
    imm_b  = ((s >>> 31) << 12) | (int'(instr[7]) << 11) | (int'(instr[30:25]) << 5)
             | (int'(instr[11:8]) << 1);
    imm_j  = ((s >>> 31) << 20) | (int'(instr[19:12]) << 12) | (int'(instr[20]) << 11)
             | (int'(instr[30:21]) << 1);
    e.pc   = pc;
    e.rs1  = instr[19:15];
    e.rs2  = instr[24:20];
    e.rd   = instr[11:7];
    e.f3   = f3;
    e.chk_alu = 1'b1;
    e.chk_src = 1'b1;
    e.chk_imm = 1'b1;
    legal  = 1'b1;
    writes = 1'b0;
    case (opc)
      7'h13: begin
        e.alu = (f3 == 3'd5 && f7 == 7'h20) ? 4'd7 : base_alu[f3];
        e.src = 1'b1; e.imm = imm_i; writes = 1'b1;
        if (f3 == 3'd1) legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      end
      7'h33: begin
        e.src = 1'b0; e.chk_imm = 1'b0; writes = 1'b1;
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.alu = (f7 == 7'h20) ? ((f3 == 3'd0) ? 4'd1 : 4'd7) : base_alu[f3];
      end
      7'h37: begin e.alu = 4'd10; e.chk_src = 1'b0; e.imm = instr & 32'hFFFFF000; writes = 1'b1; end
      7'h17: begin e.alu = 4'd11; e.chk_src = 1'b0; e.imm = instr & 32'hFFFFF000; writes = 1'b1; end
      7'h03: begin
        e.alu = 4'd0; e.src = 1'b1; e.imm = imm_i; e.cls = CL_LOAD; writes = 1'b1;
        legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      7'h23: begin
        e.alu = 4'd0; e.src = 1'b1; e.imm = imm_s; e.cls = CL_STORE;
        legal = f3 inside {3'd0, 3'd1, 3'd2};
      end
      7'h63: begin
        e.alu = 4'd1; e.src = 1'b0; e.imm = imm_b; e.cls = CL_BRANCH;
        legal = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      end
      7'h6F: begin e.chk_alu = 1'b0; e.chk_src = 1'b0; e.imm = imm_j; e.cls = CL_JAL; writes = 1'b1; end
      7'h67: begin e.alu = 4'd0; e.src = 1'b1; e.imm = imm_i; e.cls = CL_JALR; writes = 1'b1; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e.alu = 4'd0; e.chk_alu = 1'b1; e.chk_src = 1'b0; e.chk_imm = 1'b0;
      e.cls = 5'd0; writes = 1'b0;
    end
    e.rw  = writes && (e.rd != 5'd0);
    e.ill = !legal;
    return e;
  endfunction

  // Mostly valid opcodes, with funct7 biased toward the interesting values.
  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0, 9: w[6:0] = 7'h13;
      1:    w[6:0] = 7'h33;
      2:    w[6:0] = 7'h37;
      3:    w[6:0] = 7'h17;
      4:    w[6:0] = 7'h03;
      5:    w[6:0] = 7'h23;
      6:    w[6:0] = 7'h63;
      7:    w[6:0] = 7'h6F;
      8:    w[6:0] = 7'h67;
      default: ;
    endcase
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
    end
    return w;
  endfunction

  // Model state: is a bundle held, and what it must contain.
  bit   m_valid;
  exp_t m_exp;

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      if (m_exp.chk_alu) chk("alu_ctrl", 32'(alu_ctrl), 32'(m_exp.alu));
      if (m_exp.chk_src) chk("alu_src", 32'(alu_src), 32'(m_exp.src));
      if (m_exp.chk_imm) chk("imm", imm, m_exp.imm);
      chk("pc_out", pc_out, m_exp.pc);
      chk("rs1", 32'(rs1), 32'(m_exp.rs1));
      chk("rs2", 32'(rs2), 32'(m_exp.rs2));
      chk("rd", 32'(rd), 32'(m_exp.rd));
      chk("reg_write", 32'(reg_write), 32'(m_exp.rw));
      chk("class", 32'({is_load, is_store, is_branch, is_jal, is_jalr}), 32'(m_exp.cls));
      chk("funct3", 32'(funct3_out), 32'(m_exp.f3));
      chk("illegal", 32'(illegal), 32'(m_exp.ill));
    end
  endtask

  // One clock with the currently driven inputs; entered and left at posedge+1.
  task automatic cycle();
    bit acc;
    #3;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    acc = in_valid && (!m_valid || out_ready);
    if (flush_in) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1;
      m_exp   = ref_decode(in_instr, in_pc);
    end else if (out_ready) m_valid = 1'b0;
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_bundle"}, {28'd0, alu_ctrl} | imm | pc_out | 32'({rs1, rs2, rd, funct3_out}),
        32'd0);
    chk({tag, "_flags"}, 32'({alu_src, reg_write, is_load, is_store, is_branch, is_jal,
                              is_jalr, illegal}), 32'd0);
  endtask

  initial begin
    base_alu = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    rst_in    = 1'b1;
    flush_in  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    m_valid   = 1'b0;
    m_exp     = '0;
    repeat (2) @(posedge clk_in);
    #1;
    check_all_zero("reset");
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    rst_in = 1'b0;

    // Idle cycle after reset: nothing appears, stage ready.
    cycle();

    // addi x1, x0, 5
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
    cycle();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_alu", 32'(alu_ctrl), 32'd0);
    chk("addi_src", 32'(alu_src), 32'd1);
    chk("addi_imm", imm, 32'd5);
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_rw", 32'(reg_write), 32'd1);

    // sub x0, x1, x2 (back-to-back with the addi draining)
    in_instr = 32'h40208033; in_pc = 32'h104;
    cycle();
    chk("sub_alu", 32'(alu_ctrl), 32'd1);
    chk("sub_src", 32'(alu_src), 32'd0);
    chk("sub_rs1", 32'(rs1), 32'd1);
    chk("sub_rs2", 32'(rs2), 32'd2);
    chk("sub_rw", 32'(reg_write), 32'd0);

    in_valid = 1'b0;
    cycle();

    // addi x2, x0, -1 held under a 3-cycle stall while a second instruction waits.
    in_valid = 1'b1; in_instr = 32'hFFF00113; in_pc = 32'h200; out_ready = 1'b0;
    cycle();
    in_instr = 32'h00A00193; in_pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("stall_imm", imm, 32'hFFFFFFFF);
      chk("stall_pc", pc_out, 32'h200);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("release_pc", pc_out, 32'h204);
    chk("release_imm", imm, 32'd10);

    // Four-instruction stream at full rate.
    for (int k = 0; k < 4; k++) begin
      in_instr = gen_instr(); in_pc = 32'h300 + 32'(4 * k);
      cycle();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_pc", pc_out, 32'h300 + 32'(4 * k));
    end

    // Flush with a held bundle and a new offer: both must vanish.
    in_instr = 32'h00100093; in_pc = 32'h400; flush_in = 1'b1; out_ready = 1'b0;
    cycle();
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush_in = 1'b0; in_valid = 1'b0;
    cycle();
    chk("flush_after", 32'(out_valid), 32'd0);

    // Illegal all-ones word, then an asynchronous reset while it is stalled.
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h500; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_rw", 32'(reg_write), 32'd0);
    rst_in = 1'b1;
    #1;
    check_all_zero("async_rst");
    #1;
    rst_in = 1'b0;
    m_valid = 1'b0;
    m_exp = '0;
    @(posedge clk_in);
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Randomized traffic with backpressure and occasional flushes.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush_in  = ($urandom_range(0, 15) == 0);
      in_instr  = gen_instr();
      in_pc     = $urandom & 32'hFFFFFFFC;
      cycle();
    end

    in_valid = 1'b0; flush_in = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
